// File: rtl/ex_ma_skid_stage_pkg.sv
// Shared pipeline package: stage-buffer state encoding and the EX->MA control bundle.
package ex_ma_skid_stage_pkg;

    // Stage-buffer occupancy states; the encoding equals the number of held entries.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Control bundle carried alongside each instruction.
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
        logic branch;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/ex_ma_skid_stage_pipe_entry_reg.sv
// Load-enabled payload register with asynchronous active-low clear.
module pipe_entry_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d when load is asserted; hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_ma_skid_stage.sv
// EX->MA two-entry skid buffer: HEAD drives the MA side, SKID absorbs one extra
// entry so in_ready can be registered without losing throughput.
module ex_ma_skid_stage
    import ex_ma_skid_stage_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RA_W        = 5,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc_plus_4,
    input  logic [XLEN-1:0]        in_alu_result,
    input  logic [XLEN-1:0]        in_write_data,
    input  logic [RA_W-1:0]        in_rd_addr,
    input  logic                   in_mem_read,
    input  logic                   in_mem_write,
    input  logic                   in_reg_write,
    input  logic                   in_mem_to_reg,
    input  logic                   in_branch,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc_plus_4,
    output logic [XLEN-1:0]        out_alu_result,
    output logic [XLEN-1:0]        out_write_data,
    output logic [RA_W-1:0]        out_rd_addr,
    output logic                   out_mem_read,
    output logic                   out_mem_write,
    output logic                   out_reg_write,
    output logic                   out_mem_to_reg,
    output logic                   out_branch,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int unsigned ENTRY_W = 3 * XLEN + RA_W + CTRL_W;

    logic [1:0]             state_q, state_d;
    logic                   in_ready_q;
    logic [STALL_CNT_W-1:0] stall_q;
    logic                   xfer_in, xfer_out;
    logic                   head_load, skid_load, head_from_skid;
    ctrl_t                  in_ctrl, head_ctrl;
    logic [ENTRY_W-1:0]     in_entry, head_d, head_q, skid_q;

    assign in_ctrl  = {in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg, in_branch};
    assign in_entry = {in_pc_plus_4, in_alu_result, in_write_data, in_rd_addr, in_ctrl};

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign xfer_in   = in_valid & in_ready_q;
    assign xfer_out  = out_valid & out_ready;
    assign head_d    = head_from_skid ? skid_q : in_entry;

    // Occupancy transitions and entry-register load selection; flush overrides all transfers.
    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        state_d   = ST_ONE;
                        head_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (xfer_in && xfer_out) begin
                        head_load = 1'b1;
                    end else if (xfer_out) begin
                        state_d = ST_EMPTY;
                    end else if (xfer_in) begin
                        state_d   = ST_FULL;
                        skid_load = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (xfer_out) begin
                        state_d        = ST_ONE;
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State register; in_ready is registered from the next state so it never sees out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    // Saturating count of cycles where MA back-pressures a valid entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_q != '1)) begin
            stall_q <= stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    pipe_entry_reg #(.W(ENTRY_W)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (head_load),
        .d     (head_d),
        .q     (head_q)
    );

    pipe_entry_reg #(.W(ENTRY_W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .d     (in_entry),
        .q     (skid_q)
    );

    assign {out_pc_plus_4, out_alu_result, out_write_data, out_rd_addr, head_ctrl} = head_q;

    assign out_mem_read   = head_ctrl.mem_read  & out_valid;
    assign out_mem_write  = head_ctrl.mem_write & out_valid;
    assign out_reg_write  = head_ctrl.reg_write & out_valid;
    assign out_mem_to_reg = head_ctrl.mem_to_reg;
    assign out_branch     = head_ctrl.branch;
    assign occupancy      = state_q;
    assign stall_cycles   = stall_q;

endmodule
